// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared SECDED sizing helpers, data-position map and error class enum
// Positions are 1-based; power-of-2 positions carry Hamming check bits.
package secded_pkg;

   localparam int SECDED_K_DEF = 8;
   localparam int SECDED_R_DEF = 4;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_SINGLE,
      ERR_DOUBLE
   } err_t;

   function automatic int cw_bits(input int k, input int r);
      return k + r + 1;
   endfunction

   function automatic int syn_bits(input int r);
      return r;
   endfunction

   function automatic bit is_pow2(input int x);
      return (x > 0) && ((x & (x - 1)) == 0);
   endfunction

   // Position of data bit j: the j-th position (from 0) that is not a power of two.
   function automatic int data_to_pos(input int j);
      int cnt;
      cnt = 0;
      for (int p = 3; p < 4096; p++) begin
         if (!is_pow2(p)) begin
            if (cnt == j) return p;
            cnt++;
         end
      end
      return 0;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational codeword to {syndrome, overall parity}
// Shared by the SECDED encoder and decoder.
module secded_syndrome
   import secded_pkg::*;
#(
   parameter int DATA_BITS   = SECDED_K_DEF,
   parameter int PARITY_BITS = SECDED_R_DEF
) (
   input  logic [cw_bits(DATA_BITS, PARITY_BITS):1] i_cw,
   output logic [PARITY_BITS-1:0]                   o_syn,
   output logic                                     o_par
);

   localparam int CW = cw_bits(DATA_BITS, PARITY_BITS);

   always_comb begin
      o_syn = '0;
      for (int p = 1; p < CW; p++) begin
         if (i_cw[p]) o_syn = o_syn ^ PARITY_BITS'(p);
      end
      o_par = ^i_cw;
   end

endmodule

// File: rtl/secded_decoder_pipe.sv
// rtl/secded_decoder_pipe.sv - two-stage SECDED decoder with valid/ready and saturating error counters
// SECDED_DEC_ERR_INJECT_EN adds inj_mask, XORed into the codeword as it enters stage 1.
module secded_decoder_pipe
   import secded_pkg::*;
#(
   parameter int DATA_BITS   = SECDED_K_DEF,
   parameter int PARITY_BITS = SECDED_R_DEF,
   parameter int CNT_W       = 16
) (
   input  logic                                     clk,
   input  logic                                     reset_b,
   input  logic [cw_bits(DATA_BITS, PARITY_BITS):1] cw_in,
`ifdef SECDED_DEC_ERR_INJECT_EN
   input  logic [cw_bits(DATA_BITS, PARITY_BITS):1] inj_mask,
`endif
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic [DATA_BITS-1:0]                     data_out,
   output logic                                     err_single,
   output logic                                     err_double,
   output logic [PARITY_BITS:0]                     err_pos,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   input  logic                                     cnt_clr,
   output logic [CNT_W-1:0]                         single_cnt,
   output logic [CNT_W-1:0]                         double_cnt
);

   localparam int CW = cw_bits(DATA_BITS, PARITY_BITS);

   logic [CW:1]            w_cw_in;
   logic [PARITY_BITS-1:0] w_syn;
   logic                   w_par;
   logic [DATA_BITS-1:0]   w_raw_data;
   logic                   w_stall;
   logic                   w_retire;

   logic                   r_s1_valid;
   logic [DATA_BITS-1:0]   r_s1_data;
   logic [PARITY_BITS-1:0] r_s1_syn;
   logic                   r_s1_par;

   err_t                   w_cls;
   logic [PARITY_BITS:0]   w_pos;
   logic                   w_flip;
   logic [DATA_BITS-1:0]   w_fix_data;

   logic                   r_s2_valid;
   logic [DATA_BITS-1:0]   r_s2_data;
   err_t                   r_s2_err;
   logic [PARITY_BITS:0]   r_s2_pos;
   logic [CNT_W-1:0]       r_single_cnt;
   logic [CNT_W-1:0]       r_double_cnt;

`ifdef SECDED_DEC_ERR_INJECT_EN
   assign w_cw_in = cw_in ^ inj_mask;
`else
   assign w_cw_in = cw_in;
`endif

   // A stalled output freezes both stages together, so no bubble is ever inserted.
   assign w_stall  = r_s2_valid & ~out_ready;
   assign w_retire = r_s2_valid & out_ready;
   assign in_ready = ~w_stall;

   secded_syndrome #(
      .DATA_BITS   (DATA_BITS),
      .PARITY_BITS (PARITY_BITS)
   ) u_syndrome (
      .i_cw  (w_cw_in),
      .o_syn (w_syn),
      .o_par (w_par)
   );

   always_comb begin
      w_raw_data = '0;
      for (int j = 0; j < DATA_BITS; j++) begin
         w_raw_data[j] = w_cw_in[data_to_pos(j)];
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_syn   <= '0;
         r_s1_par   <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_data <= w_raw_data;
            r_s1_syn  <= w_syn;
            r_s1_par  <= w_par;
         end
      end
   end

   always_comb begin
      w_cls  = ERR_NONE;
      w_pos  = '0;
      w_flip = 1'b0;
      if (r_s1_par) begin
         if (r_s1_syn == '0) begin
            w_cls = ERR_SINGLE;
            w_pos = (PARITY_BITS + 1)'(CW);
         end else if (int'(r_s1_syn) <= CW - 1) begin
            w_cls  = ERR_SINGLE;
            w_pos  = {1'b0, r_s1_syn};
            w_flip = 1'b1;
         end else begin
            w_cls = ERR_DOUBLE;
         end
      end else if (r_s1_syn != '0) begin
         w_cls = ERR_DOUBLE;
      end
   end

   // Only data positions matter downstream; a flipped check bit needs no repair.
   always_comb begin
      w_fix_data = r_s1_data;
      for (int j = 0; j < DATA_BITS; j++) begin
         if (w_flip && (r_s1_syn == PARITY_BITS'(data_to_pos(j)))) begin
            w_fix_data[j] = ~r_s1_data[j];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_err   <= ERR_NONE;
         r_s2_pos   <= '0;
      end else if (!w_stall) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= w_fix_data;
            r_s2_err  <= w_cls;
            r_s2_pos  <= w_pos;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_single_cnt <= '0;
         r_double_cnt <= '0;
      end else if (cnt_clr) begin
         r_single_cnt <= '0;
         r_double_cnt <= '0;
      end else begin
         if (w_retire && (r_s2_err == ERR_SINGLE) && (r_single_cnt != '1)) begin
            r_single_cnt <= r_single_cnt + 1'b1;
         end
         if (w_retire && (r_s2_err == ERR_DOUBLE) && (r_double_cnt != '1)) begin
            r_double_cnt <= r_double_cnt + 1'b1;
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign data_out   = r_s2_data;
   assign err_single = (r_s2_err == ERR_SINGLE);
   assign err_double = (r_s2_err == ERR_DOUBLE);
   assign err_pos    = r_s2_pos;
   assign single_cnt = r_single_cnt;
   assign double_cnt = r_double_cnt;

endmodule
